prbs_lfsr_gen: RTL
==================

// Module: prbs_lfsr_gen
// PURPOSE
//  Parametrised Galois-LFSR PRBS source. Generates OUT_W bits per output word with a valid/ready handshake.
//  Supports runtime seed load, all-zero lock-up protection and sequence-wrap detection.
//  Feeds test-pattern and scrambler paths in the sequence-generator group.
// PARAMETERS
//  WIDTH         16       LFSR state width (>=3)
//  TAPS          16'hB400 Galois feedback mask, bit k = tap; default x^16+x^14+x^13+x^11+1 (maximal)
//  OUT_W         8        PRBS bits per output word (1..WIDTH)
//  DEFAULT_SEED  1        state after reset / replacement for an all-zero seed (must be non-zero)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous reset, active high
//  enable     in   1       allow generation of new words
//  seed_load  in   1       load seed into LFSR this cycle
//  seed       in   WIDTH   seed value, sampled when seed_load=1
//  out_ready  in   1       consumer accepts out_data
//  out_valid  out  1       out_data holds a valid word
//  out_data   out  OUT_W   PRBS word, earliest bit in [0]
//  state      out  WIDTH   current LFSR state
//  wrap       out  1       1-cycle pulse: LFSR returned to start value
//  lockup     out  1       1-cycle pulse: all-zero seed was rejected
// BEHAVIOUR
//  Single step: b = s[0]; s' = (s >> 1) ^ (b ? TAPS : 0). The output bit is b.
//  Word generation: unroll OUT_W steps combinationally from state.
//   - out_data[i] = output bit of step i.
//   - next state = state after OUT_W steps.
//  start_reg holds the last accepted seed. Reset value = DEFAULT_SEED.
//  Reset (async):
//   - state = start_reg = DEFAULT_SEED
//   - out_valid = 0; out_data = 0; wrap = 0; lockup = 0
//  Per-cycle priority, highest first:
//   1. seed_load:
//      - state and start_reg <= (seed==0 ? DEFAULT_SEED : seed)
//      - lockup <= (seed==0)
//      - out_valid <= 0, flushing any held word. A same-cycle valid&ready transfer still counts as done.
//   2. enable && (!out_valid || out_ready):
//      - out_data <= next word; state <= advanced state; out_valid <= 1
//      - This gives back-to-back words every cycle while out_ready=1.
//   3. out_valid && out_ready: out_valid <= 0.
//   4. Otherwise hold all registers.
//  Latency: first word is valid 1 cycle after enable rises with the output empty. Throughput is 1 word/clk.
//  Handshake rules:
//   - out_data is stable while out_valid && !out_ready.
//   - Dropping enable never drops a held word.
//  wrap: 1-cycle pulse in the cycle after an advance whose new state == start_reg. Never set by seed_load itself.
//  A zero state is unreachable: seed is guarded and TAPS is maximal by requirement.
//  Reset mid-stream aborts the current word immediately; no handshake completes.
// CONFIGURATION
//  LFSR_ERR_INJECT_EN defined:
//   - adds input err_inject (1 bit).
//   - If err_inject=1 in a cycle where a word is generated, that word's out_data[0] is inverted.
//   - LFSR state and the wrap check are unaffected, so the following words are correct.
//  LFSR_ERR_INJECT_EN undefined: port absent; out_data is always the pure sequence.
// TESTING (WIDTH=4, TAPS=4'hC, DEFAULT_SEED=1 unless noted)
//  1. OUT_W=1, reset, enable=1, ready=1:
//     -> bits 1,0,0,1,1,0,1,0,1,1,1,1,0,0,0, then repeat; wrap pulses once per 15 words.
//  2. OUT_W=4, reset, enable=1, ready=1:
//     -> out_data 4'h9, 4'h5, 4'hF, 4'h8; state after 1st word = 4'hD.
//  3. OUT_W=4, ready=0 for 5 cycles after 1st word:
//     -> out_data holds 4'h9, out_valid=1, state frozen at 4'hD; ready=1 -> next word 4'h5.
//  4. seed_load with seed=0:
//     -> lockup=1 for 1 cycle, state=4'h1, out_valid=0 next cycle, no X.
//  5. Assert rst mid-stream with out_valid=1:
//     -> out_valid=0, state=4'h1 immediately; sequence restarts at bit pattern of test 1.
//  6. LFSR_ERR_INJECT_EN, OUT_W=4, err_inject on 2nd word:
//     -> words 4'h9, 4'h4, 4'hF; wrap timing unchanged.

Source files
------------

// File: rtl/prbs_lfsr_gen.sv
// ============================================================================
// Module   : prbs_lfsr_gen
// Purpose  : Galois-LFSR PRBS source. It produces OUT_W bits per word over a
//            valid/ready handshake, with seed load, zero-seed guard and wrap
//            detect. The optional macro LFSR_ERR_INJECT_EN adds err_inject,
//            which flips bit 0 of a generated word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_lfsr_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
`ifdef LFSR_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [WIDTH-1:0] state,
    output logic             wrap,
    output logic             lockup
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic             r_wrap;
    logic             r_lockup;

    logic [WIDTH-1:0] w_step;
    logic [OUT_W-1:0] w_bits;
    logic [OUT_W-1:0] w_word;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_seed_val;
    logic             w_advance;

    // Unroll OUT_W single steps; the earliest output bit lands in bit 0.
    always_comb begin
        w_step = r_state;
        w_bits = '0;
        for (int i = 0; i < OUT_W; i++) begin
            w_bits[i] = w_step[0];
            w_step    = {1'b0, w_step[WIDTH-1:1]} ^ (w_step[0] ? TAPS : '0);
        end
    end

    always_comb begin
        w_word = w_bits;
`ifdef LFSR_ERR_INJECT_EN
        w_word[0] = w_bits[0] ^ err_inject;
`endif
    end

    assign w_seed_zero = (seed == '0);
    assign w_seed_val  = w_seed_zero ? DEFAULT_SEED : seed;
    assign w_advance   = enable && (!r_valid || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= DEFAULT_SEED;
            r_start  <= DEFAULT_SEED;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
        end else begin
            r_wrap   <= 1'b0;
            r_lockup <= 1'b0;
            if (seed_load) begin
                r_state  <= w_seed_val;
                r_start  <= w_seed_val;
                r_lockup <= w_seed_zero;
                r_valid  <= 1'b0;
            end else if (w_advance) begin
                r_data  <= w_word;
                r_state <= w_step;
                r_valid <= 1'b1;
                // Wrap compares against the seed the current run started from.
                r_wrap  <= (w_step == r_start);
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign state     = r_state;
    assign wrap      = r_wrap;
    assign lockup    = r_lockup;

endmodule

`default_nettype wire
